// File: rtl/cplx_acc_quant_if.sv
// ============================================================================
// Module : cplx_acc_quant_if
// Brief  : Accumulation input stream and quantised valid/ready output stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cplx_acc_quant_if #(
  parameter int PW = 58,
  parameter int OW = 16
);
  logic          in_vld;
  logic [PW-1:0] in_r;
  logic [PW-1:0] in_i;
  logic          out_vld;
  logic          out_rdy;
  logic [OW-1:0] out_r;
  logic [OW-1:0] out_i;

  modport master (
    output in_vld, in_r, in_i, out_rdy,
    input  out_vld, out_r, out_i
  );

  modport slave (
    input  in_vld, in_r, in_i, out_rdy,
    output out_vld, out_r, out_i
  );
endinterface

`default_nettype wire

// File: rtl/cplx_acc_quant.sv
// ============================================================================
// Module : cplx_acc_quant
// Brief  : Round/shift/saturate complex accumulations to OW bits, buffer in a
//          show-ahead FIFO with sticky saturation and drop flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cplx_acc_quant #(
  parameter int PW    = 58,
  parameter int OW    = 16,
  parameter int SHIFT = 20,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  cplx_acc_quant_if.slave                 bus,
  output logic [$clog2(DEPTH+1)-1:0]      level,
  output logic                            sat_err,
  output logic                            drop_err,
  input  wire logic                       clr_err
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [PW:0] c_rnd =
    (SHIFT > 0) ? ((PW+1)'(1) << ((SHIFT > 0) ? SHIFT-1 : 0)) : '0;

  // {sat flag, value}: in range when every bit above the OW-bit sign agrees with it
  function automatic logic [OW:0] f_sat(input logic signed [PW:0] v);
    logic [PW-OW+1:0] top;
    top = v[PW:OW-1];
    if ((&top) || (~|top)) begin
      f_sat = {1'b0, v[OW-1:0]};
    end else if (v[PW]) begin
      f_sat = {1'b1, 1'b1, {(OW-1){1'b0}}};
    end else begin
      f_sat = {1'b1, 1'b0, {(OW-1){1'b1}}};
    end
  endfunction

  logic                 r_s1_vld;
  logic signed [PW:0]   r_s1_r;
  logic signed [PW:0]   r_s1_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_r   <= '0;
      r_s1_i   <= '0;
    end else begin
      r_s1_vld <= bus.in_vld;
      r_s1_r   <= $signed({bus.in_r[PW-1], bus.in_r}) + c_rnd;
      r_s1_i   <= $signed({bus.in_i[PW-1], bus.in_i}) + c_rnd;
    end
  end

  logic signed [PW:0] w_sh_r;
  logic signed [PW:0] w_sh_i;
  logic [OW:0]        w_q_r;
  logic [OW:0]        w_q_i;

  assign w_sh_r = r_s1_r >>> SHIFT;
  assign w_sh_i = r_s1_i >>> SHIFT;
  assign w_q_r  = f_sat(w_sh_r);
  assign w_q_i  = f_sat(w_sh_i);

  logic          r_s2_vld;
  logic          r_s2_sat;
  logic [OW-1:0] r_s2_r;
  logic [OW-1:0] r_s2_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_sat <= 1'b0;
      r_s2_r   <= '0;
      r_s2_i   <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_sat <= w_q_r[OW] | w_q_i[OW];
      r_s2_r   <= w_q_r[OW-1:0];
      r_s2_i   <= w_q_i[OW-1:0];
    end
  end

  logic [OW-1:0] r_mem_r [DEPTH];
  logic [OW-1:0] r_mem_i [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_sat_err;
  logic          r_drop_err;

  logic w_out_vld;
  logic w_full;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  assign w_out_vld = (r_level != '0);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_rd      = w_out_vld & bus.out_rdy;
  // a read on the same edge frees the slot the full-FIFO write needs
  assign w_wr      = r_s2_vld & (~w_full | w_rd);
  assign w_drop    = r_s2_vld & w_full & ~w_rd;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem_r[gi] <= '0;
        r_mem_i[gi] <= '0;
      end else if (w_wr && (r_wr_ptr == AW'(gi))) begin
        r_mem_r[gi] <= r_s2_r;
        r_mem_i[gi] <= r_s2_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // a set event on the clearing edge wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_err  <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_sat_err  <= (r_s2_vld & r_s2_sat) | (r_sat_err & ~clr_err);
      r_drop_err <= w_drop | (r_drop_err & ~clr_err);
    end
  end

  assign bus.out_vld = w_out_vld;
  assign bus.out_r   = r_mem_r[r_rd_ptr];
  assign bus.out_i   = r_mem_i[r_rd_ptr];
  assign level       = r_level;
  assign sat_err     = r_sat_err;
  assign drop_err    = r_drop_err;

endmodule

`default_nettype wire

// File: tb/tb_cplx_acc_quant.sv
// ============================================================================
// Module : tb_cplx_acc_quant
// Brief  : Directed scoreboard bench for cplx_acc_quant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cplx_acc_quant;
  localparam int PW = 58, OW = 16, SHIFT = 20, DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] level;
  logic       sat_err, drop_err;

  cplx_acc_quant_if #(.PW(PW), .OW(OW)) bus ();

  cplx_acc_quant #(.PW(PW), .OW(OW), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .level(level),
    .sat_err(sat_err), .drop_err(drop_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] sb[$];
  bit          chk_lvl1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // round-half-up then saturate, done in plain 64-bit integer arithmetic
  function automatic logic [15:0] model(input longint x);
    longint t;
    t = (x + (longint'(1) << (SHIFT-1))) >>> SHIFT;
    if (t > 32767)  return 16'h7fff;
    if (t < -32768) return 16'h8000;
    return t[15:0];
  endfunction

  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (bus.out_vld && bus.out_rdy) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", {bus.out_r, bus.out_i}, e);
      end
    end
    if (chk_lvl1) chk("level_le1", 32'(level <= 3'd1), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic put(input longint xr, input longint xi);
    bus.in_vld = 1'b1;
    bus.in_r   = xr[PW-1:0];
    bus.in_i   = xi[PW-1:0];
    step();
    bus.in_vld = 1'b0;
  endtask

  task automatic drive(input longint xr, input longint xi, input bit keep);
    if (keep) sb.push_back({model(xr), model(xi)});
    put(xr, xi);
  endtask

  task automatic drive_lit(input longint xr, input longint xi, input logic [31:0] e);
    sb.push_back(e);
    put(xr, xi);
  endtask

  initial begin
    longint v;
    bus.in_vld  = 1'b0;
    bus.in_r    = '0;
    bus.in_i    = '0;
    bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_data", {bus.out_r, bus.out_i}, 32'd0);
    chk("rst_flags", {30'd0, sat_err, drop_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: tie rounding and latency
    bus.out_rdy = 1'b1;
    drive_lit(longint'(3) << 19, -(longint'(3) << 19), {16'd2, 16'hffff});
    step();
    chk("lat_2", 32'(bus.out_vld), 32'd0);
    step();
    chk("lat_3", 32'(bus.out_vld), 32'd1);
    step();
    step();
    chk("t1_sat", 32'(sat_err), 32'd0);
    chk("t1_empty", 32'(bus.out_vld), 32'd0);

    // 2: saturation both directions, then clear
    drive_lit(longint'(1) << 40, -(longint'(1) << 40), {16'h7fff, 16'h8000});
    repeat (3) step();
    chk("t2_sat", 32'(sat_err), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t2_clr", 32'(sat_err), 32'd0);

    // 3: overfill with consumer stalled
    bus.out_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) drive(longint'(i) << 20, -(longint'(i) << 20), i <= 4);
    repeat (3) step();
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_drop", 32'(drop_err), 32'd1);
    chk("t3_vld", 32'(bus.out_vld), 32'd1);
    bus.out_rdy = 1'b1;
    repeat (4) step();
    chk("t3_level0", 32'(level), 32'd0);
    chk("t3_vld0", 32'(bus.out_vld), 32'd0);

    // 4: write and read on the same edge while full
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t4_clr", 32'(drop_err), 32'd0);
    bus.out_rdy = 1'b0;
    for (int i = 7; i <= 10; i++) drive(longint'(i) << 20, longint'(i) << 20, 1'b1);
    repeat (2) step();
    chk("t4_full", 32'(level), 32'd4);
    drive(longint'(11) << 20, longint'(11) << 20, 1'b1);
    step();
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    chk("t4_level", 32'(level), 32'd4);
    chk("t4_drop", 32'(drop_err), 32'd0);
    bus.out_rdy = 1'b1;
    repeat (4) step();
    chk("t4_level0", 32'(level), 32'd0);

    // 5: full-rate streaming
    chk_lvl1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = $signed({$urandom, $urandom}) >>> ((i % 3 == 0) ? 24 : 30);
      drive(v, -v + longint'(i), 1'b1);
    end
    repeat (4) step();
    chk_lvl1 = 1'b0;
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    chk("t5_drop", 32'(drop_err), 32'd0);
    chk("t5_level", 32'(level), 32'd0);

    // 6: reset with stored and in-flight results
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    bus.out_rdy = 1'b0;
    drive(longint'(1) << 40, 0, 1'b0);
    for (int i = 2; i <= 4; i++) drive(longint'(i) << 20, 0, 1'b0);
    chk("t6_level2", 32'(level), 32'd2);
    chk("t6_sat", 32'(sat_err), 32'd1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_vld", 32'(bus.out_vld), 32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_flags", {30'd0, sat_err, drop_err}, 32'd0);
    rst_n = 1'b1;
    bus.out_rdy = 1'b1;
    repeat (5) step();
    chk("t6_no_stale", 32'(bus.out_vld), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

`default_nettype wire
